// File: rtl/transaccion_pkg.sv
// transaccion_pkg: state encoding shared by the transaction control block
package transaccion_pkg;
  localparam int STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;
endpackage

// File: rtl/control_transaccion_if.sv
// control_transaccion_if: FIFO status, thresholds and state flags of the control block
interface control_transaccion_if
  import transaccion_pkg::*;
#(
  parameter int NUM_FIFOS = 5,
  parameter int UMBRAL_W  = 3,
  parameter int ERRCNT_W  = 4
);
  logic                 init;
  logic                 err_clr;
  logic [UMBRAL_W-1:0]  umbralMF, umbralVC, umbralD;
  logic [NUM_FIFOS-1:0] fifo_empties, fifo_errors;
  logic                 init_out, idle_out, active_out, error_out;
  logic [UMBRAL_W-1:0]  umbralMF_out, umbralVC_out, umbralD_out;
  logic [STATE_W-1:0]   state, next_state;
  logic [NUM_FIFOS-1:0] error_mask;
  logic [ERRCNT_W-1:0]  error_count;
  modport master (
    output init, err_clr, umbralMF, umbralVC, umbralD, fifo_empties, fifo_errors,
    input  init_out, idle_out, active_out, error_out, umbralMF_out, umbralVC_out, umbralD_out,
           state, next_state, error_mask, error_count
  );
  modport slave (
    input  init, err_clr, umbralMF, umbralVC, umbralD, fifo_empties, fifo_errors,
    output init_out, idle_out, active_out, error_out, umbralMF_out, umbralVC_out, umbralD_out,
           state, next_state, error_mask, error_count
  );
endinterface

// File: rtl/contador_sat.sv
// contador_sat: up counter that sticks at all ones; clr beats inc
module contador_sat #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/control_transaccion.sv
// control_transaccion: RESET/INIT/IDLE/ACTIVE/ERROR sequencing for N transaction FIFOs
module control_transaccion
  import transaccion_pkg::*;
#(
  parameter int NUM_FIFOS = 5,
  parameter int UMBRAL_W  = 3,
  parameter int IDLE_DLY  = 4,
  parameter int ERR_HOLD  = 2,
  parameter int ERRCNT_W  = 4
) (
  input logic                  clk,
  input logic                  reset,
  control_transaccion_if.slave bus
);
  localparam int DMAX = IDLE_DLY > ERR_HOLD ? IDLE_DLY : ERR_HOLD;
  localparam int CW = $clog2(DMAX + 1);
  state_t               state, nxt;
  logic [CW-1:0]        dly, dly_n;
  logic [UMBRAL_W-1:0]  mf, vc, d;
  logic [NUM_FIFOS-1:0] mask;
  logic [ERRCNT_W-1:0]  cnt;
  logic                 all_empty, any_err, qual;
  assign all_empty = &bus.fifo_empties;
  assign any_err = |bus.fifo_errors;
  always_comb begin
    nxt = ST_RESET;
    case (state)
      ST_RESET:  nxt = ST_INIT;
      ST_INIT:   nxt = ST_IDLE;
      ST_IDLE:   nxt = bus.init ? ST_INIT : any_err ? ST_ERROR : all_empty ? ST_IDLE : ST_ACTIVE;
      ST_ACTIVE: nxt = bus.init ? ST_INIT : any_err ? ST_ERROR :
                       (all_empty && dly == CW'(IDLE_DLY - 1)) ? ST_IDLE : ST_ACTIVE;
      ST_ERROR:  nxt = any_err ? ST_ERROR : dly == CW'(ERR_HOLD - 1) ? ST_RESET : ST_ERROR;
      default:   nxt = ST_RESET;
    endcase
  end
  // one counter serves both the ACTIVE idle run and the ERROR clean run
  assign qual = (state == ST_ACTIVE && all_empty) || (state == ST_ERROR && !any_err);
  assign dly_n = (nxt != state || !qual) ? '0 : dly + 1'b1;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= ST_RESET;
      dly <= '0;
      mf <= '0;
      vc <= '0;
      d <= '0;
      mask <= '0;
    end else begin
      state <= nxt;
      dly <= dly_n;
      mask <= bus.err_clr ? '0 : mask | bus.fifo_errors;
      if (state == ST_INIT) begin
        mf <= bus.umbralMF;
        vc <= bus.umbralVC;
        d <= bus.umbralD;
      end
    end
  contador_sat #(.W(ERRCNT_W)) u_errcnt (
    .clk  (clk),
    .reset(reset),
    .inc  (nxt == ST_ERROR && state != ST_ERROR),
    .clr  (bus.err_clr),
    .cnt  (cnt)
  );
  assign bus.state = state;
  assign bus.next_state = nxt;
  assign bus.init_out = state == ST_INIT;
  assign bus.idle_out = state == ST_IDLE;
  assign bus.active_out = state == ST_ACTIVE;
  assign bus.error_out = state == ST_ERROR;
  assign bus.umbralMF_out = mf;
  assign bus.umbralVC_out = vc;
  assign bus.umbralD_out = d;
  assign bus.error_mask = mask;
  assign bus.error_count = cnt;
endmodule

// File: tb/tb_control_transaccion.sv
// tb_control_transaccion: directed vectors against hand-computed states, flags and counters
module tb_control_transaccion;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int fails = 0;
  control_transaccion_if #(.NUM_FIFOS(5), .UMBRAL_W(3), .ERRCNT_W(2)) bus ();
  control_transaccion #(
    .NUM_FIFOS(5), .UMBRAL_W(3), .IDLE_DLY(4), .ERR_HOLD(2), .ERRCNT_W(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_st(input string tag, input logic [2:0] exp);
    chk(tag, {29'd0, bus.state}, {29'd0, exp});
    chk({tag, "_flags"}, {28'd0, bus.init_out, bus.idle_out, bus.active_out, bus.error_out},
        {28'd0, exp == 3'd1, exp == 3'd2, exp == 3'd3, exp == 3'd4});
  endtask
  initial begin
    bus.init = 0;
    bus.err_clr = 0;
    bus.umbralMF = 3'd5;
    bus.umbralVC = 3'd3;
    bus.umbralD = 3'd1;
    bus.fifo_empties = 5'b11111;
    bus.fifo_errors = 5'b00000;
    #12;
    chk_st("rst_state", 3'd0);
    chk("rst_mf", bus.umbralMF_out, 0);
    chk("rst_mask", bus.error_mask, 0);
    chk("rst_cnt", bus.error_count, 0);
    reset = 0;
    tick(); chk_st("edge1_init", 3'd1);
    tick(); chk_st("edge2_idle", 3'd2);
    chk("umbral_mf", bus.umbralMF_out, 5);
    chk("umbral_vc", bus.umbralVC_out, 3);
    chk("umbral_d", bus.umbralD_out, 1);
    bus.umbralMF = 0; bus.umbralVC = 0; bus.umbralD = 0;
    tick(); chk_st("idle_stay", 3'd2);
    chk("umbral_hold", bus.umbralMF_out, 5);
    bus.fifo_empties = 5'b11101;
    #1 chk("next_active", bus.next_state, 3);
    tick(); chk_st("to_active", 3'd3);
    bus.fifo_empties = 5'b11111;
    for (int i = 0; i < 3; i++) begin tick(); chk_st("active_3empty", 3'd3); end
    bus.fifo_empties = 5'b11101;
    tick(); chk_st("active_busy", 3'd3);
    bus.fifo_empties = 5'b11111;
    for (int i = 0; i < 3; i++) begin tick(); chk_st("active_restart", 3'd3); end
    tick(); chk_st("debounced_idle", 3'd2);
    bus.fifo_empties = 5'b11101;
    tick(); chk_st("active_again", 3'd3);
    bus.fifo_errors = 5'b00100;
    tick(); chk_st("to_error", 3'd4);
    chk("mask_err", bus.error_mask, 5'b00100);
    chk("cnt_1", bus.error_count, 1);
    tick(); chk_st("err_stay1", 3'd4);
    tick(); chk_st("err_stay2", 3'd4);
    bus.fifo_errors = 0;
    tick(); chk_st("err_hold", 3'd4);
    tick(); chk_st("err_to_reset", 3'd0);
    chk("mask_sticky", bus.error_mask, 5'b00100);
    chk("cnt_sticky", bus.error_count, 1);
    tick(); chk_st("reinit", 3'd1);
    tick(); chk_st("reidle", 3'd2);
    chk("umbral_reload", bus.umbralMF_out, 0);
    bus.err_clr = 1;
    tick(); chk("clr_mask", bus.error_mask, 0);
    chk("clr_cnt", bus.error_count, 0);
    bus.err_clr = 0;
    bus.fifo_empties = 5'b11101;
    tick(); chk_st("active3", 3'd3);
    bus.init = 1; bus.fifo_errors = 5'b00001;
    tick(); chk_st("init_wins", 3'd1);
    chk("mask_init", bus.error_mask, 5'b00001);
    chk("cnt_init", bus.error_count, 0);
    bus.init = 0; bus.fifo_errors = 0; bus.fifo_empties = 5'b11111;
    tick(); chk_st("idle_after_init", 3'd2);
    for (int i = 0; i < 4; i++) begin
      bus.fifo_errors = 5'b00010;
      tick(); chk_st("sat_err", 3'd4);
      chk("sat_cnt", bus.error_count, (i < 3) ? i + 1 : 3);
      bus.fifo_errors = 0; bus.init = 1;
      tick(); chk_st("err_ignores_init", 3'd4);
      tick(); chk_st("sat_reset", 3'd0);
      bus.init = 0;
      tick(); tick(); chk_st("sat_idle", 3'd2);
    end
    bus.fifo_errors = 5'b01000; bus.err_clr = 1;
    tick(); chk_st("clr_err", 3'd4);
    chk("clr_beats_set", bus.error_mask, 0);
    chk("clr_beats_inc", bus.error_count, 0);
    bus.err_clr = 0; bus.fifo_errors = 0;
    tick(); chk_st("still_err", 3'd4);
    #2 reset = 1;
    #1;
    chk_st("async_rst", 3'd0);
    chk("async_next", bus.next_state, 1);
    chk("async_mf", bus.umbralMF_out, 0);
    chk("async_mask", bus.error_mask, 0);
    chk("async_cnt", bus.error_count, 0);
    #10 reset = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
